// File: rtl/pool_wr_sched.sv
// Row scheduler feeding the pooling BRAM writer: buffers one pooled row and issues one writer run per row.
// Optional writer watchdog is built when POOL_SCHED_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module pool_wr_sched #(
   parameter int OCH    = 6,
   parameter int OY     = 14,
   parameter int OX     = 14,
   parameter int O_F_BW = 8,
   parameter int TO_CYC = 64
) (
   input  logic                       clk,
   input  logic                       areset,
   input  logic                       i_start,
   input  logic                       i_row_valid,
   input  logic [OX*O_F_BW-1:0]       i_row_pool,
   output logic                       o_row_ready,
   output logic                       o_wr_run,
   output logic [$clog2(OY)-1:0]      o_wr_oy_idx,
   output logic [$clog2(OCH)-1:0]     o_wr_och_idx,
   output logic [OX*O_F_BW-1:0]       o_wr_ox_pool,
   input  logic                       i_wr_ot_done,
   input  logic                       i_wr_en_err,
   output logic                       o_idle,
   output logic                       o_busy,
   output logic                       o_done,
   output logic                       o_err
);

   localparam int ROW_W = OX * O_F_BW;
   localparam int OY_W  = $clog2(OY);
   localparam int OCH_W = $clog2(OCH);
   localparam int TOTAL = OCH * OY;
   localparam int CNT_W = $clog2(TOTAL + 1);

   // Upstream handshake: a row moves when i_row_valid && o_row_ready at a clock edge;
   // o_row_ready depends only on registered state, never on i_row_valid.

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FILL  = 3'd1,
      S_ISSUE = 3'd2,
      S_WAIT  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic               busy;
   logic               buf_full;
   logic [ROW_W-1:0]   row_buf;
   logic [OY_W-1:0]    oy_idx;
   logic [OCH_W-1:0]   och_idx;
   logic [CNT_W-1:0]   rows_acc;
   logic               last_issued;
   logic               err;
   logic               row_xfer;
   logic               start_idle;
   logic               last_row;
   logic               timeout;

   assign busy        = (state != S_IDLE);
   assign o_row_ready = busy && !buf_full && (rows_acc < CNT_W'(TOTAL));
   assign row_xfer    = i_row_valid && o_row_ready;
   assign start_idle  = i_start && (state == S_IDLE);
   assign last_row    = (oy_idx == OY_W'(OY - 1)) && (och_idx == OCH_W'(OCH - 1));

`ifdef POOL_SCHED_TIMEOUT_EN
   localparam int TO_W = $clog2(TO_CYC + 1);
   logic [TO_W-1:0] to_cnt;

   // Held at zero outside WAIT, so every entry into WAIT starts a fresh count.
   always_ff @(posedge clk) begin
      if (areset || (state != S_WAIT)) begin
         to_cnt <= '0;
      end else begin
         to_cnt <= to_cnt + 1'b1;
      end
   end

   assign timeout = (state == S_WAIT) && !i_wr_ot_done && (to_cnt == TO_W'(TO_CYC - 1));
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (areset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      o_wr_run  = 1'b0;
      o_done    = 1'b0;
      o_busy    = busy;
      o_idle    = !busy;
      case (state)
         S_IDLE: begin
            if (i_start) state_nxt = S_FILL;
         end
         S_FILL: begin
            if (buf_full) state_nxt = S_ISSUE;
         end
         S_ISSUE: begin
            o_wr_run  = 1'b1;
            state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (i_wr_ot_done) begin
               if (last_issued) begin
                  state_nxt = S_DONE;
               end else if (buf_full) begin
                  state_nxt = S_ISSUE;
               end else begin
                  state_nxt = S_FILL;
               end
            end else if (timeout) begin
               state_nxt = S_IDLE;
            end
         end
         S_DONE: begin
            o_done    = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Row buffer, indices and counters. A transfer can never coincide with ISSUE
   // because ISSUE is only reached with the buffer full.
   always_ff @(posedge clk) begin
      if (areset) begin
         buf_full    <= 1'b0;
         row_buf     <= '0;
         oy_idx      <= '0;
         och_idx     <= '0;
         rows_acc    <= '0;
         last_issued <= 1'b0;
      end else if (start_idle) begin
         buf_full    <= 1'b0;
         oy_idx      <= '0;
         och_idx     <= '0;
         rows_acc    <= '0;
         last_issued <= 1'b0;
      end else begin
         if (row_xfer) begin
            row_buf  <= i_row_pool;
            buf_full <= 1'b1;
            rows_acc <= rows_acc + 1'b1;
         end
         if (state == S_ISSUE) begin
            buf_full    <= 1'b0;
            last_issued <= last_row;
            if (och_idx == OCH_W'(OCH - 1)) begin
               och_idx <= '0;
               oy_idx  <= oy_idx + 1'b1;
            end else begin
               och_idx <= och_idx + 1'b1;
            end
         end
         if (timeout) begin
            buf_full <= 1'b0;
         end
      end
   end

   // Sticky error: a start while idle clears it, any error source in the same cycle wins.
   always_ff @(posedge clk) begin
      if (areset) begin
         err <= 1'b0;
      end else begin
         err <= (start_idle ? 1'b0 : err)
              | (i_start && busy)
              | i_wr_en_err
              | (i_wr_ot_done && (state != S_WAIT))
              | timeout;
      end
   end

   assign o_err        = err;
   assign o_wr_oy_idx  = oy_idx;
   assign o_wr_och_idx = och_idx;
   assign o_wr_ox_pool = row_buf;

endmodule
